imem_loader: RTL

//  Write-side companion of the byte-wide instruction memory. Receives a framed byte

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   Holds the loader FSM state encoding, the frame length-field width and a
//   helper that decides whether a received payload length fits in memory.
package imem_loader_pkg;

  // Width of the big-endian length field at the head of every frame.
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // True when a payload of n bytes fits in a memory of max_bytes bytes.
  function automatic logic len_fits(input logic [LEN_W-1:0] n, input int unsigned max_bytes);
    return {{(32-LEN_W){1'b0}}, n} <= max_bytes;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: writes a framed byte stream (LEN_HI, LEN_LO, payload, CSUM) into
//   the byte-wide instruction memory, payload byte k at address k.
// Latency: memory write is combinational from the accepted byte; done/error and
//   cpu_hold release are visible one cycle after the final (CSUM) transfer.
// Backpressure: never stalls while loading (in_ready=1 in LEN_HI..CSUM); in_ready=0
//   in IDLE/DONE/ERR, so bytes offered there are simply not consumed.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 one-cycle load request (ignored while busy)
//   in_valid/in_ready/in_data   byte stream
//   mem_we/mem_addr/mem_wdata   byte write port of the instruction memory
//   busy, done, error     load status (done/error sticky until next start)
//   cpu_hold              core held unless last load finished cleanly
//   load_len              payload length from the last received header
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 1024  // power of two; also the largest accepted payload
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [LEN_W-1:0]  load_len
);

  localparam int AW = $clog2(MEM_BYTES);

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        len_hi;
  // Only the low byte of the running sum is ever compared, so the
  // accumulator is kept at 8 bits (identical to a wider sum mod 256).
  logic [7:0]        sum;
  logic              done_q;
  logic              error_q;
  logic              xfer;
  logic              restart;
  logic [LEN_W-1:0]  len_word;

  assign xfer     = in_valid & in_ready;
  assign len_word = {len_hi, in_data};
  assign restart  = start & ((state == ST_IDLE) | (state == ST_DONE) | (state == ST_ERR));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (xfer) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (xfer) begin
          if (len_word == '0)                              state_nxt = ST_CSUM;
          else if (len_fits(len_word, MEM_BYTES))          state_nxt = ST_DATA;
          else                                             state_nxt = ST_ERR;
        end
      end
      ST_DATA: begin
        // Last payload byte: the count after this edge equals N.
        if (xfer && (count + 16'd1 == len_q)) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        if (xfer) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
    mem_we    = (state == ST_DATA) & in_valid;
    mem_addr  = {{(32-AW){1'b0}}, count[AW-1:0]};
    mem_wdata = in_data;
    cpu_hold  = ~((state == ST_DONE) & ~error_q);
  end

  // Header capture, byte counter, checksum and sticky status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      len_q   <= '0;
      len_hi  <= '0;
      sum     <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (restart) begin
      count   <= '0;
      sum     <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (xfer) begin
      case (state)
        ST_LEN_HI: len_hi <= in_data;
        ST_LEN_LO: begin
          len_q <= len_word;
          if (!len_fits(len_word, MEM_BYTES)) begin
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end
        end
        ST_DATA: begin
          count <= count + 16'd1;
          sum   <= sum + in_data;
        end
        ST_CSUM: begin
          done_q  <= 1'b1;
          error_q <= (in_data != sum);
        end
        default: ;
      endcase
    end
  end

  assign done     = done_q;
  assign error    = error_q;
  assign load_len = len_q;

endmodule
